fb_write_arbiter: RTL and testbench

- Owns the single write port of the 176x120, 3-bit RGB111 frame buffer (dual-port RAM, write side on the 25 MHz pixel clock).
- Shares the port between two pixel-write requesters (game FSM, overlay/score drawer) and a built-in clear engine that fills the whole buffer with one colour.
- Drives the RAM write address, data and write strobe directly; the VGA read side is untouched.

---
 rtl/fb_write_arbiter_pkg.sv | 22 ++
 rtl/fb_clear_counter.sv | 39 +++
 rtl/fb_write_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_fb_write_arbiter.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_write_arbiter_pkg.sv
// Shared constants, colours and FSM encoding for the frame-buffer write-port arbiter.
// The optional out-of-range write guard in fb_write_arbiter is enabled by BOUNDS_CHECK_EN.
package fb_write_arbiter_pkg;

    localparam int unsigned SCREEN_X = 176;
    localparam int unsigned SCREEN_Y = 120;
    localparam int unsigned AW       = 15;
    localparam int unsigned DW       = 3;
    localparam int unsigned PIXELS   = SCREEN_X * SCREEN_Y;

    localparam logic [DW-1:0] RED   = 3'b100;
    localparam logic [DW-1:0] GREEN = 3'b010;
    localparam logic [DW-1:0] BLUE  = 3'b001;
    localparam logic [DW-1:0] BLACK = 3'b000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } fb_state_e;

endpackage

// File: rtl/fb_clear_counter.sv
// Linear address counter for the clear-fill engine; saturates on the last pixel.
module fb_clear_counter #(
    parameter int unsigned AW   = fb_write_arbiter_pkg::AW,
    parameter int unsigned LAST = fb_write_arbiter_pkg::PIXELS - 1
) (
    input  logic          clk,
    input  logic          rst_ni,
    input  logic          start_i,
    input  logic          adv_i,
    output logic [AW-1:0] next_c_o,
    output logic          last_c_o
);

    logic [AW-1:0] cnt_q;
    logic [AW-1:0] cnt_d;

    assign last_c_o = (cnt_q == AW'(LAST));

    // start wins over advance; advancing past the last pixel is blocked
    always_comb begin
        cnt_d = cnt_q;
        if (start_i) begin
            cnt_d = '0;
        end else if (adv_i && !last_c_o) begin
            cnt_d = cnt_q + AW'(1);
        end
    end

    assign next_c_o = cnt_d;

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fb_write_arbiter.sv
// Single write port of the RGB111 frame buffer, shared by two requesters and a clear-fill engine.
// Define BOUNDS_CHECK_EN to suppress out-of-range writes and expose the sticky oob_err flag.
module fb_write_arbiter #(
    parameter int unsigned SCREEN_X = fb_write_arbiter_pkg::SCREEN_X,
    parameter int unsigned SCREEN_Y = fb_write_arbiter_pkg::SCREEN_Y,
    parameter int unsigned AW       = fb_write_arbiter_pkg::AW,
    parameter int unsigned DW       = fb_write_arbiter_pkg::DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] data0,
    output logic          gnt0,
    input  logic          req1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] data1,
    output logic          gnt1,
    input  logic          clear_start,
    input  logic [DW-1:0] clear_color,
    output logic          clear_busy,
    output logic          clear_done,
    output logic [AW-1:0] mem_px_addr,
    output logic [DW-1:0] mem_px_data,
    output logic          px_wr
`ifdef BOUNDS_CHECK_EN
    ,
    output logic          oob_err
`endif
);

    import fb_write_arbiter_pkg::*;

    localparam int unsigned NPIX = SCREEN_X * SCREEN_Y;

    fb_state_e     state_q, state_d;
    logic          gnt0_q, gnt0_d;
    logic          gnt1_q, gnt1_d;
    logic          wr_q, wr_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          rr_q, rr_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] data_q, data_d;
    logic [DW-1:0] color_q, color_d;
`ifdef BOUNDS_CHECK_EN
    logic          oob_q, oob_d;
`endif

    logic          cnt_start;
    logic          cnt_adv;
    logic [AW-1:0] cnt_next;
    logic          cnt_last;
    logic          elig0;
    logic          elig1;
    logic          pick1;

    fb_clear_counter #(
        .AW   (AW),
        .LAST (NPIX - 1)
    ) u_clear_counter (
        .clk      (clk),
        .rst_ni   (rst),
        .start_i  (cnt_start),
        .adv_i    (cnt_adv),
        .next_c_o (cnt_next),
        .last_c_o (cnt_last)
    );

    // A requester whose grant is currently on the port is not eligible this cycle
    assign elig0 = req0 && !gnt0_q;
    assign elig1 = req1 && !gnt1_q;
    assign pick1 = elig1 && (!elig0 || rr_q);

    always_comb begin
        state_d   = state_q;
        gnt0_d    = 1'b0;
        gnt1_d    = 1'b0;
        wr_d      = 1'b0;
        busy_d    = busy_q;
        done_d    = 1'b0;
        rr_d      = rr_q;
        addr_d    = addr_q;
        data_d    = data_q;
        color_d   = color_q;
        cnt_start = 1'b0;
        cnt_adv   = 1'b0;
`ifdef BOUNDS_CHECK_EN
        oob_d     = oob_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (clear_start) begin
                    state_d   = CLEAR;
                    color_d   = clear_color;
                    cnt_start = 1'b1;
                    wr_d      = 1'b1;
                    addr_d    = cnt_next;
                    data_d    = clear_color;
                    busy_d    = 1'b1;
                end else if (elig0 || elig1) begin
                    gnt0_d = !pick1;
                    gnt1_d = pick1;
                    rr_d   = !pick1;
                    addr_d = pick1 ? addr1 : addr0;
                    data_d = pick1 ? data1 : data0;
                    wr_d   = 1'b1;
`ifdef BOUNDS_CHECK_EN
                    if ({1'b0, addr_d} >= (AW+1)'(NPIX)) begin
                        wr_d  = 1'b0;
                        oob_d = 1'b1;
                    end
`endif
                end
            end
            CLEAR: begin
                busy_d = 1'b1;
                if (cnt_last) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    cnt_adv = 1'b1;
                    wr_d    = 1'b1;
                    addr_d  = cnt_next;
                    data_d  = color_q;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            wr_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rr_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            color_q <= '0;
`ifdef BOUNDS_CHECK_EN
            oob_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
            wr_q    <= wr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            rr_q    <= rr_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            color_q <= color_d;
`ifdef BOUNDS_CHECK_EN
            oob_q   <= oob_d;
`endif
        end
    end

    assign gnt0        = gnt0_q;
    assign gnt1        = gnt1_q;
    assign px_wr       = wr_q;
    assign clear_busy  = busy_q;
    assign clear_done  = done_q;
    assign mem_px_addr = addr_q;
    assign mem_px_data = data_q;
`ifdef BOUNDS_CHECK_EN
    assign oob_err     = oob_q;
`endif

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Randomized bench for fb_write_arbiter against a behavioural model of the write-port rules.
module tb_fb_write_arbiter;

    localparam int unsigned AW   = 15;
    localparam int unsigned DW   = 3;
    localparam int unsigned NPIX = 176 * 120;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0, req1, gnt0, gnt1;
    logic [AW-1:0] addr0, addr1, mem_px_addr;
    logic [DW-1:0] data0, data1, clear_color, mem_px_data;
    logic          clear_start, clear_busy, clear_done, px_wr;
`ifdef BOUNDS_CHECK_EN
    logic          oob_err;
`endif

    fb_write_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .req0        (req0),
        .addr0       (addr0),
        .data0       (data0),
        .gnt0        (gnt0),
        .req1        (req1),
        .addr1       (addr1),
        .data1       (data1),
        .gnt1        (gnt1),
        .clear_start (clear_start),
        .clear_color (clear_color),
        .clear_busy  (clear_busy),
        .clear_done  (clear_done),
        .mem_px_addr (mem_px_addr),
        .mem_px_data (mem_px_data),
        .px_wr       (px_wr)
`ifdef BOUNDS_CHECK_EN
        ,
        .oob_err     (oob_err)
`endif
    );

    always #20 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: clr_pos = next fill index to emit, NPIX = done pulse due,
    // NPIX+1 = quiet cycle after done, -1 = port free for requesters.
    int            clr_pos;
    int            last_gnt;
    logic [DW-1:0] m_color;
    logic          e_gnt0, e_gnt1, e_wr, e_busy, e_done, e_oob;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data;

    bit agents_on;
    bit hold_both;
    int rate;
    int clr_writes;
    int done_pulses;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s at %0t: got=%0h want=%0h", tag, $time, got, want);
        end
    endtask

    function automatic logic [31:0] dut_vec();
        return 32'({gnt0, gnt1, px_wr, clear_busy, clear_done, mem_px_addr, mem_px_data});
    endfunction

    function automatic logic [31:0] exp_vec();
        return 32'({e_gnt0, e_gnt1, e_wr, e_busy, e_done, e_addr, e_data});
    endfunction

    function automatic logic [AW-1:0] rand_addr();
        if ($urandom_range(0, 7) == 0) return AW'(NPIX + $urandom_range(0, 15));
        return AW'($urandom_range(0, NPIX - 1));
    endfunction

    task automatic model_reset();
        clr_pos  = -1;
        last_gnt = 1;
        m_color  = '0;
        e_gnt0 = 1'b0; e_gnt1 = 1'b0; e_wr = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_oob = 1'b0;
        e_addr = '0;
        e_data = '0;
    endtask

    // Predict the outputs of the next cycle from the inputs applied in this one.
    task automatic model_step();
        bit a0, a1, take1;
        a0 = req0 && !e_gnt0;
        a1 = req1 && !e_gnt1;
        e_gnt0 = 1'b0; e_gnt1 = 1'b0; e_wr = 1'b0; e_done = 1'b0;
        if (clr_pos < 0 && clear_start) begin
            m_color = clear_color;
            clr_pos = 0;
        end
        if (clr_pos >= 0) begin
            if (clr_pos < int'(NPIX)) begin
                e_wr   = 1'b1;
                e_addr = AW'(clr_pos);
                e_data = m_color;
                e_busy = 1'b1;
                clr_pos++;
            end else if (clr_pos == int'(NPIX)) begin
                e_done = 1'b1;
                e_busy = 1'b0;
                clr_pos++;
            end else begin
                clr_pos = -1;
            end
        end else if (a0 || a1) begin
            take1    = a1 && (!a0 || last_gnt == 0);
            last_gnt = take1 ? 1 : 0;
            e_gnt0   = !take1;
            e_gnt1   = take1;
            e_addr   = take1 ? addr1 : addr0;
            e_data   = take1 ? data1 : data0;
            e_wr     = 1'b1;
`ifdef BOUNDS_CHECK_EN
            if (int'(e_addr) >= int'(NPIX)) begin
                e_wr  = 1'b0;
                e_oob = 1'b1;
            end
`endif
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check("outs", dut_vec(), exp_vec());
`ifdef BOUNDS_CHECK_EN
        check("oob_err", 32'(oob_err), 32'(e_oob));
`endif
        if (clear_done) done_pulses++;
        if (px_wr && clear_busy) clr_writes++;
        clear_start = 1'b0;
        clear_color = DW'($urandom);
        if (gnt0) req0 = 1'b0;
        if (gnt1) req1 = 1'b0;
        if (!req0 && (hold_both || (agents_on && $urandom_range(0, 99) < rate))) begin
            req0 = 1'b1; addr0 = rand_addr(); data0 = DW'($urandom);
        end
        if (!req1 && (hold_both || (agents_on && $urandom_range(0, 99) < rate))) begin
            req1 = 1'b1; addr1 = rand_addr(); data1 = DW'($urandom);
        end
    endtask

    task automatic run_clear(input logic [DW-1:0] color);
        bit fin;
        fin         = 1'b0;
        clr_writes  = 0;
        done_pulses = 0;
        clear_start = 1'b1;
        clear_color = color;
        for (int i = 0; i < int'(NPIX) + 20; i++) begin
            cycle();
            if (clr_pos == 101 && !req1) begin
                req1 = 1'b1; addr1 = AW'(333); data1 = 3'b110;
            end
            if (clr_pos == 5000) begin
                clear_start = 1'b1; clear_color = 3'b111;
            end
            if (clr_pos < 0) begin
                fin = 1'b1;
                break;
            end
        end
        check("clear_finished", 32'(fin), 32'd1);
        check("clear_writes", 32'(clr_writes), 32'(NPIX));
        check("clear_done_pulses", 32'(done_pulses), 32'd1);
    endtask

    initial begin
        rst = 1'b0;
        req0 = 1'b0; req1 = 1'b0;
        addr0 = '0; addr1 = '0; data0 = '0; data1 = '0;
        clear_start = 1'b0; clear_color = '0;
        agents_on = 1'b0; hold_both = 1'b0; rate = 30;
        clr_writes = 0; done_pulses = 0;
        model_reset();
        #50;
        check("reset_outs", dut_vec(), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        cycle();

        // single requester, then drop
        req0 = 1'b1; addr0 = AW'(177); data0 = 3'b010;
        repeat (4) cycle();

        // first out-of-range address, then a valid one
        req0 = 1'b1; addr0 = AW'(NPIX); data0 = 3'b111;
        repeat (2) cycle();
        req0 = 1'b1; addr0 = AW'(5); data0 = 3'b100;
        repeat (3) cycle();

        // both requesters held high
        hold_both = 1'b1;
        repeat (8) cycle();
        hold_both = 1'b0;
        repeat (4) cycle();

        // random arbitration with varying load
        agents_on = 1'b1;
        for (int blk = 0; blk < 15; blk++) begin
            rate = $urandom_range(10, 95);
            repeat (100) cycle();
        end

        // full clear with a request arriving mid-fill and an ignored restart
        agents_on = 1'b0;
        repeat (6) cycle();
        run_clear(3'b001);
        repeat (6) cycle();
        agents_on = 1'b1;
        rate = 40;
        repeat (300) cycle();

        // reset in the middle of a clear
        agents_on = 1'b0;
        clear_start = 1'b1;
        clear_color = 3'b100;
        for (int i = 0; i < 700; i++) begin
            cycle();
            if (clr_pos == 501) break;
        end
        check("reached_addr_500", 32'(clr_pos), 32'd501);
        #5 rst = 1'b0;
        #1;
        check("rst_mid_clear", dut_vec(), 32'd0);
`ifdef BOUNDS_CHECK_EN
        check("rst_mid_clear_oob", 32'(oob_err), 32'd0);
`endif
        model_reset();
        done_pulses = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        agents_on = 1'b1;
        rate = 50;
        repeat (200) cycle();
        check("no_done_after_rst", 32'(done_pulses), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
